// File: rtl/regfile_mp_if.sv
// Register file port bundle: one write port, two read ports,
// clear request and ready status.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic              clr;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              ready;

    modport master (
        output we, waddr, wdata, ra1, ra2, clr,
        input  rdata1, rdata2, ready
    );

    modport slave (
        input  we, waddr, wdata, ra1, ra2, clr,
        output rdata1, rdata2, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with write-first bypass,
// optional hardwired zero entry and sequenced clear.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic              wr_ok;
    logic              zero1, zero2;
    logic              byp1, byp2;

    // A write survives only in RUN without clr and not aimed at a hardwired zero
    always_comb begin
        wr_ok = bus.we && !bus.clr
             && !(ZR && bus.waddr == '0);
        zero1 = ZR && bus.ra1 == '0;
        zero2 = ZR && bus.ra2 == '0;
        byp1  = wr_ok && bus.waddr == bus.ra1;
        byp2  = wr_ok && bus.waddr == bus.ra2;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        rdata1_d = '0;
        rdata2_d = '0;
        mem_we   = 1'b0;
        mem_wa   = bus.waddr;
        mem_wd   = bus.wdata;
        unique case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                if (zero1)     rdata1_d = '0;
                else if (byp1) rdata1_d = bus.wdata;
                else           rdata1_d = mem_q[bus.ra1];
                if (zero2)     rdata2_d = '0;
                else if (byp2) rdata2_d = bus.wdata;
                else           rdata2_d = mem_q[bus.ra2];
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else begin
                    mem_we = wr_ok;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    // Storage has no reset; the clear sequence initialises it
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign bus.rdata1 = rdata1_q;
    assign bus.rdata2 = rdata2_q;
    assign bus.ready  = ready_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: two instances (zero entry on/off)
// share stimulus and are checked against an array-based model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        clr;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) if0 ();

    assign if1.we = we;
    assign if1.waddr = waddr;
    assign if1.wdata = wdata;
    assign if1.ra1 = ra1;
    assign if1.ra2 = ra2;
    assign if1.clr = clr;
    assign if0.we = we;
    assign if0.waddr = waddr;
    assign if0.wdata = wdata;
    assign if0.ra1 = ra1;
    assign if0.ra2 = ra2;
    assign if0.clr = clr;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    int nvec = 0;
    int nbad = 0;

    // Reference model: a clear is a 32-edge busy window after which
    // everything reads zero, so memory is zeroed as soon as it starts.
    logic [31:0] mem1 [32];
    logic [31:0] mem0 [32];
    bit          busy = 1'b0;
    int          left = 0;
    logic        e_ready = 1'b0;
    logic [31:0] e11 = '0, e12 = '0, e01 = '0, e02 = '0;
    logic [129:0] got_v, exp_v;

    function automatic logic [31:0] mval(input bit zr, input logic [4:0] a);
        if (zr && a == 5'd0) return 32'd0;
        if (we && !clr && !(zr && waddr == 5'd0) && waddr == a) return wdata;
        return zr ? mem1[a] : mem0[a];
    endfunction

    task automatic start_clear();
        busy = 1'b1;
        left = 32;
        for (int i = 0; i < 32; i++) begin
            mem1[i] = '0;
            mem0[i] = '0;
        end
    endtask

    task automatic step();
        if (!rst) begin
            start_clear();
            e_ready = 1'b0;
            {e11, e12, e01, e02} = '0;
        end else if (busy) begin
            left--;
            {e11, e12, e01, e02} = '0;
            if (left == 0) begin
                busy = 1'b0;
                e_ready = 1'b1;
            end
        end else begin
            e11 = mval(1'b1, ra1);
            e12 = mval(1'b1, ra2);
            e01 = mval(1'b0, ra1);
            e02 = mval(1'b0, ra2);
            if (clr) begin
                start_clear();
                e_ready = 1'b0;
            end else if (we) begin
                if (waddr != 5'd0) mem1[waddr] = wdata;
                mem0[waddr] = wdata;
            end
        end
        @(posedge clk);
        #1;
        got_v = {if1.ready, if1.rdata1, if1.rdata2, if0.ready, if0.rdata1, if0.rdata2};
        exp_v = {e_ready, e11, e12, e_ready, e01, e02};
    endtask

    task automatic idle();
        we = 1'b0;
        clr = 1'b0;
        waddr = '0;
        wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++;
            if (got_v !== exp_v) begin
                nbad++;
                $display("FAIL reset_hold cyc %0d got %h want %h", i, got_v, exp_v);
            end
        end
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            we = 1'($urandom);
            waddr = 5'($urandom);
            wdata = $urandom;
            step();
            nvec++;
            if (got_v !== exp_v || if1.ready !== (i == 32)) begin
                nbad++;
                $display("FAIL reset_clear edge %0d got %h want %h", i, got_v, exp_v);
            end
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            step();
            nvec++;
            if (got_v !== exp_v || if0.rdata1 !== 32'd0 || if0.rdata2 !== 32'd0) begin
                nbad++;
                $display("FAIL reset_zero entry %0d got %h want %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        step();
        waddr = 5'd31;
        wdata = 32'h12345678;
        step();
        idle();
        ra1 = 5'd5;
        ra2 = 5'd31;
        step();
        nvec++;
        if (got_v !== exp_v || if1.rdata1 !== 32'hDEADBEEF || if1.rdata2 !== 32'h12345678) begin
            nbad++;
            $display("FAIL write_read got %h/%h want deadbeef/12345678", if1.rdata1, if1.rdata2);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1;
        waddr = 5'd7;
        wdata = 32'h1;
        step();
        wdata = 32'hA5A5A5A5;
        ra1 = 5'd7;
        ra2 = 5'd7;
        step();
        nvec++;
        if (got_v !== exp_v || if1.rdata1 !== 32'hA5A5A5A5 || if0.rdata2 !== 32'hA5A5A5A5) begin
            nbad++;
            $display("FAIL bypass got %h want %h", got_v, exp_v);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        we = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFFFFFF;
        ra1 = 5'd0;
        ra2 = 5'd5;
        step();
        nvec++;
        if (got_v !== exp_v || if1.rdata1 !== 32'd0 || if0.rdata1 !== 32'hFFFFFFFF) begin
            nbad++;
            $display("FAIL zero_same got %h/%h want 0/ffffffff", if1.rdata1, if0.rdata1);
        end
        idle();
        step();
        nvec++;
        if (got_v !== exp_v || if1.rdata1 !== 32'd0 || if0.rdata1 !== 32'hFFFFFFFF) begin
            nbad++;
            $display("FAIL zero_next got %h/%h want 0/ffffffff", if1.rdata1, if0.rdata1);
        end
    endtask

    task automatic test_clr();
        we = 1'b1;
        for (int i = 1; i < 32; i++) begin
            waddr = 5'(i);
            wdata = 32'(i);
            ra1 = 5'($urandom);
            ra2 = 5'(i);
            step();
        end
        clr = 1'b1;
        waddr = 5'd3;
        wdata = 32'h99;
        ra1 = 5'd3;
        ra2 = 5'd30;
        step();
        nvec++;
        if (got_v !== exp_v || if1.ready !== 1'b0 || if0.rdata2 !== 32'd30) begin
            nbad++;
            $display("FAIL clr_edge got %h want %h", got_v, exp_v);
        end
        clr = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            we = 1'b1;
            waddr = 5'($urandom);
            wdata = $urandom | 32'h1;
            clr = 1'($urandom);
            step();
            nvec++;
            if (got_v !== exp_v || if0.ready !== (i == 32)) begin
                nbad++;
                $display("FAIL clr_seq edge %0d got %h want %h", i, got_v, exp_v);
            end
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'd3;
            step();
            nvec++;
            if (got_v !== exp_v || if0.rdata1 !== 32'd0 || if0.rdata2 !== 32'd0) begin
                nbad++;
                $display("FAIL clr_zero entry %0d got %h want %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_rst_mid_clear();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 1; i < 10; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            nvec++;
            if (got_v !== exp_v || if1.ready !== (i == 32)) begin
                nbad++;
                $display("FAIL rst_mid_clear edge %0d got %h want %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom);
            waddr = 5'($urandom_range(0, 7));
            wdata = $urandom;
            ra1 = 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            clr = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 199) != 0);
            step();
            nvec++;
            if (got_v !== exp_v) begin
                nbad++;
                $display("FAIL random cyc %0d got %h want %h", i, got_v, exp_v);
            end
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        ra1 = '0;
        ra2 = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clr();
        test_rst_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
